// File: rtl/cnn_pkg.sv
// Purpose: shared types and helpers for the CNN layer sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cnn_pkg;

    // Sequencer control states.
    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        FINISH,
        ERROR
    } seq_state_t;

    // Error classification reported on err_code.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_TIMEOUT  = 2'd1,
        ERR_SPURIOUS = 2'd2
    } err_code_t;

    localparam int ERR_W = 2;

    // Width of a stage index; at least one bit so a single-stage build still has a port.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cnn_layer_sequencer_if.sv
// Purpose: frame handshake, engine start/done and status bundle of the layer sequencer.
// Latency: n/a (wiring only).
// Backpressure: frame_valid/frame_ready handshake; engines are start/done pulse driven.
interface cnn_layer_sequencer_if #(
    parameter int NUM_STAGES = 3,
    parameter int CYC_W      = 32
);
    import cnn_pkg::*;

    localparam int SEL_W = sel_width(NUM_STAGES);

    logic                  frame_valid;
    logic                  frame_ready;
    logic                  abort;
    logic                  clear_err;
    logic [NUM_STAGES-1:0] stage_start;
    logic [NUM_STAGES-1:0] stage_done;
    logic [SEL_W-1:0]      stage_sel;
    logic                  busy;
    logic                  done;
    logic                  error;
    logic [ERR_W-1:0]      err_code;
    logic [SEL_W-1:0]      err_stage;
    logic [CYC_W-1:0]      frame_cycles;

    // Sequencer side.
    modport master (
        input  frame_valid, abort, clear_err, stage_done,
        output frame_ready, stage_start, stage_sel, busy, done,
               error, err_code, err_stage, frame_cycles
    );

    // Host / engine side.
    modport slave (
        output frame_valid, abort, clear_err, stage_done,
        input  frame_ready, stage_start, stage_sel, busy, done,
               error, err_code, err_stage, frame_cycles
    );

endinterface

// File: rtl/stage_watchdog.sv
// Purpose: per-stage run-time watchdog; flags a stage that runs TIMEOUT_CYCLES cycles without finishing.
// Latency: expired_o is combinational from the count register, asserted on the TIMEOUT_CYCLES-th enabled cycle.
// Backpressure: none; clear_i has priority over enable_i, TIMEOUT_CYCLES=0 never expires.
module stage_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The count visible in the last allowed cycle; it saturates there.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear on a fresh launch, otherwise count enabled cycles up to the limit.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (cnt_q == LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// Purpose: sequences NUM_STAGES layer engines per frame, owns the shared-buffer select, watchdog and status.
// Latency: first stage_start one cycle after acceptance; next start / done pulse one cycle after each stage_done.
// Backpressure: frame_ready only in IDLE, no queueing; abort cancels a running frame, errors hold until clear_err.
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_STAGES     = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1 << 20,
    parameter int unsigned CYC_W          = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    cnn_layer_sequencer_if.master bus
);

    localparam int SEL_W = sel_width(NUM_STAGES);
    localparam logic [SEL_W-1:0]      LAST_STG = SEL_W'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] STG_ONE  = NUM_STAGES'(1);
    localparam logic [CYC_W-1:0]      CYC_MAX  = '1;

    seq_state_t            state_q, state_d;
    logic [SEL_W-1:0]      stg_q, stg_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [NUM_STAGES-1:0] start_q, start_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    err_code_t             err_code_q, err_code_d;
    logic [SEL_W-1:0]      err_stage_q, err_stage_d;
    logic [CYC_W-1:0]      fc_q, fc_d;

    logic                  raise;
    err_code_t             raise_code;
    logic [NUM_STAGES-1:0] cur_mask;
    logic [SEL_W-1:0]      stg_next;
    logic                  wd_expired;

    // The watchdog restarts while the start pulse is out and counts only while the stage runs.
    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == LAUNCH),
        .enable_i (state_q == WAIT),
        .expired_o(wd_expired)
    );

    // Next-state and registered-output computation; abort outranks errors, errors outrank a valid done.
    always_comb begin
        state_d     = state_q;
        stg_d       = stg_q;
        sel_d       = sel_q;
        start_d     = '0;
        done_d      = 1'b0;
        error_d     = error_q;
        err_code_d  = err_code_q;
        err_stage_d = err_stage_q;
        // Frame time keeps running through the cycle that ends the frame, then freezes.
        fc_d        = (busy_q && (fc_q != CYC_MAX)) ? fc_q + 1'b1 : fc_q;
        raise       = 1'b0;
        raise_code  = ERR_NONE;
        cur_mask    = STG_ONE << stg_q;
        stg_next    = stg_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (|bus.stage_done) begin
                    raise      = 1'b1;
                    raise_code = ERR_SPURIOUS;
                end else if (bus.frame_valid && ready_q) begin
                    state_d = LAUNCH;
                    stg_d   = '0;
                    sel_d   = '0;
                    start_d = STG_ONE;
                    // The acceptance cycle itself is the first counted cycle of the frame.
                    fc_d    = CYC_W'(1);
                end
            end
            LAUNCH: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (|bus.stage_done) begin
                    raise      = 1'b1;
                    raise_code = ERR_SPURIOUS;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (|(bus.stage_done & ~cur_mask)) begin
                    raise      = 1'b1;
                    raise_code = ERR_SPURIOUS;
                end else if (|(bus.stage_done & cur_mask)) begin
                    if (stg_q == LAST_STG) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        // Buffer ownership moves together with the next start pulse.
                        state_d = LAUNCH;
                        stg_d   = stg_next;
                        sel_d   = stg_next;
                        start_d = STG_ONE << stg_next;
                    end
                end else if (wd_expired) begin
                    raise      = 1'b1;
                    raise_code = ERR_TIMEOUT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            ERROR: begin
                if (bus.clear_err) begin
                    state_d    = IDLE;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (raise) begin
            state_d     = ERROR;
            error_d     = 1'b1;
            err_code_d  = raise_code;
            err_stage_d = stg_q;
        end

        busy_d  = (state_d == LAUNCH) || (state_d == WAIT);
        ready_d = (state_d == IDLE);
    end

    // State and output registers; everything returns to zero / IDLE on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            stg_q       <= '0;
            sel_q       <= '0;
            start_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_code_q  <= ERR_NONE;
            err_stage_q <= '0;
            fc_q        <= '0;
        end else begin
            state_q     <= state_d;
            stg_q       <= stg_d;
            sel_q       <= sel_d;
            start_q     <= start_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_code_q  <= err_code_d;
            err_stage_q <= err_stage_d;
            fc_q        <= fc_d;
        end
    end

    assign bus.frame_ready  = ready_q;
    assign bus.stage_start  = start_q;
    assign bus.stage_sel    = sel_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.error        = error_q;
    assign bus.err_code     = err_code_q;
    assign bus.err_stage    = err_stage_q;
    assign bus.frame_cycles = fc_q;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Purpose: directed self-checking bench for cnn_layer_sequencer with modelled layer engines.
// Latency: engines answer a fixed number of cycles after their start pulse (0 = never).
// Backpressure: host drives frame_valid/abort/clear_err directly; no flow control on engines.
module tb_cnn_layer_sequencer;
    import cnn_pkg::*;

    localparam int NS = 3;
    localparam int TO = 16;
    localparam int CW = 32;

    typedef struct {
        int s0;
        int s1;
        int s2;
        int d;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [NS-1:0] eng_done;
    logic [NS-1:0] inj_done;
    int            lat [NS];
    int            cnt [NS];
    int            cyc;
    int            t0;
    bit            hold_fv;
    int            n_cmp;
    int            n_bad;
    exp_t          sb [$];
    int            o_s [NS];
    int            o_ev;
    int            o_nst;
    bit            o_selbad;
    bit            o_done;
    bit            o_err;

    cnn_layer_sequencer_if #(.NUM_STAGES(NS), .CYC_W(CW)) bus ();

    cnn_layer_sequencer #(
        .NUM_STAGES    (NS),
        .TIMEOUT_CYCLES(TO),
        .CYC_W         (CW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign bus.stage_done = eng_done | inj_done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Engine models: done pulse exactly lat[i] cycles after the cycle carrying stage_start[i].
    initial begin
        eng_done = '0;
        for (int i = 0; i < NS; i++) cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (!reset) begin
                    cnt[i]      = 0;
                    eng_done[i] = 1'b0;
                end else begin
                    eng_done[i] = 1'b0;
                    if (cnt[i] > 0) begin
                        cnt[i]--;
                        if (cnt[i] == 0) eng_done[i] = 1'b1;
                    end
                    if (bus.stage_start[i] && (lat[i] > 0)) cnt[i] = lat[i];
                end
            end
        end
    end

    // Hard stop in case the sequence itself wedges.
    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic set_lat(input int l0, input int l1, input int l2);
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
    endtask

    function automatic exp_t model(input int l0, input int l1, input int l2);
        exp_t e;
        e.s0 = 1;
        e.s1 = e.s0 + l0 + 1;
        e.s2 = e.s1 + l1 + 1;
        e.d  = e.s2 + l2 + 1;
        return e;
    endfunction

    task automatic start_frame(input bit expect_done);
        t0 = cyc;
        if (expect_done) sb.push_back(model(lat[0], lat[1], lat[2]));
        bus.frame_valid = 1'b1;
    endtask

    // Follow a frame until done or error; record start offsets and buffer-select stability.
    task automatic observe(input int budget);
        int c;
        int cur;
        bit run;
        o_ev = -1; o_nst = 0; o_selbad = 0; o_done = 0; o_err = 0;
        cur = 0; run = 0;
        for (int i = 0; i < NS; i++) o_s[i] = -1;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (!hold_fv) bus.frame_valid = 1'b0;
            c = cyc - t0;
            for (int i = 0; i < NS; i++) begin
                if (bus.stage_start[i]) begin
                    o_s[i] = c;
                    o_nst++;
                    cur = i;
                    run = 1;
                end
            end
            if (run && (int'(bus.stage_sel) != cur)) o_selbad = 1;
            if (run && bus.stage_done[cur]) run = 0;
            if (bus.done || bus.error) begin
                o_ev   = c;
                o_done = bus.done;
                o_err  = bus.error;
                return;
            end
        end
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        chk({tag, "_done_seen"}, o_done, 1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_start0"}, o_s[0], e.s0);
        chk({tag, "_start1"}, o_s[1], e.s1);
        chk({tag, "_start2"}, o_s[2], e.s2);
        chk({tag, "_done_cyc"}, o_ev, e.d);
        chk({tag, "_frame_cycles"}, bus.frame_cycles, e.d);
        chk({tag, "_num_starts"}, o_nst, 3);
        chk({tag, "_sel_stable"}, o_selbad, 0);
        chk({tag, "_busy_at_done"}, bus.busy, 0);
    endtask

    initial begin
        logic [NS-1:0] acc;
        n_cmp = 0; n_bad = 0; cyc = 0; hold_fv = 0; t0 = 0;
        reset = 1'b0;
        inj_done = '0;
        bus.frame_valid = 1'b0;
        bus.abort = 1'b0;
        bus.clear_err = 1'b0;
        set_lat(0, 0, 0);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {bus.frame_ready, bus.stage_start, bus.stage_sel, bus.busy, bus.done,
                              bus.error, bus.err_code, bus.err_stage, bus.frame_cycles}, 0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("ready_after_reset", bus.frame_ready, 1);
        chk("idle_not_busy", bus.busy, 0);

        // Abort in IDLE is ignored
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("idle_abort_ready", bus.frame_ready, 1);
        chk("idle_abort_err", bus.error, 0);

        // 1: full frame, engines answer after 5/7/9 cycles
        set_lat(5, 7, 9);
        start_frame(1);
        observe(100);
        check_frame("t1");
        tick();
        chk("t1_ready_again", bus.frame_ready, 1);

        // 2: stage 1 never answers -> timeout
        set_lat(3, 0, 3);
        start_frame(0);
        observe(80);
        chk("t2_error_seen", o_err, 1);
        chk("t2_timeout_cyc", o_ev - o_s[1], 17);
        chk("t2_err_code", bus.err_code, 1);
        chk("t2_err_stage", bus.err_stage, 1);
        chk("t2_busy", bus.busy, 0);
        chk("t2_ready", bus.frame_ready, 0);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("t2_clear_ready", bus.frame_ready, 1);
        chk("t2_clear_error", bus.error, 0);
        chk("t2_clear_code", bus.err_code, 0);

        // 3: stage_done[2] while stage 0 runs -> spurious error
        set_lat(20, 5, 5);
        start_frame(0);
        tick();
        bus.frame_valid = 1'b0;
        tick();
        tick();
        inj_done = 3'b100;
        tick();
        inj_done = '0;
        chk("t3_error", bus.error, 1);
        chk("t3_err_code", bus.err_code, 2);
        chk("t3_err_stage", bus.err_stage, 0);
        acc = '0;
        for (int n = 0; n < 25; n++) begin
            tick();
            acc = acc | bus.stage_start;
        end
        chk("t3_no_starts", acc, 0);
        chk("t3_error_sticky", bus.error, 1);
        bus.clear_err = 1'b1;
        tick();
        bus.clear_err = 1'b0;
        chk("t3_clear_ready", bus.frame_ready, 1);

        // 4: abort in the same cycle as stage_done[1]
        set_lat(3, 4, 5);
        start_frame(0);
        while ((cyc - t0) < 9) begin
            tick();
            bus.frame_valid = 1'b0;
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("t4_busy", bus.busy, 0);
        chk("t4_no_start", bus.stage_start, 0);
        chk("t4_no_done", bus.done, 0);
        chk("t4_ready", bus.frame_ready, 1);
        chk("t4_frame_cycles", bus.frame_cycles, 10);
        acc = '0;
        for (int n = 0; n < 10; n++) begin
            tick();
            acc = acc | bus.stage_start | {2'b00, bus.done};
        end
        chk("t4_quiet_after", acc, 0);
        chk("t4_cycles_frozen", bus.frame_cycles, 10);
        chk("t4_no_error", bus.error, 0);

        // 5: asynchronous reset during stage 1 WAIT, then a normal frame
        set_lat(3, 6, 3);
        start_frame(0);
        while ((cyc - t0) < 7) begin
            tick();
            bus.frame_valid = 1'b0;
        end
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_reset", {bus.frame_ready, bus.stage_start, bus.stage_sel, bus.busy, bus.done,
                               bus.error, bus.err_code, bus.err_stage, bus.frame_cycles}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        tick();
        chk("t5_ready_after", bus.frame_ready, 1);
        set_lat(5, 7, 9);
        start_frame(1);
        observe(100);
        check_frame("t5");
        tick();
        chk("t5_ready_again", bus.frame_ready, 1);

        // 6: frame_valid held high -> back-to-back frames
        set_lat(4, 2, 6);
        hold_fv = 1;
        for (int f = 0; f < 3; f++) begin
            start_frame(1);
            observe(100);
            check_frame($sformatf("t6_f%0d", f));
            if (f == 2) begin
                hold_fv = 0;
                bus.frame_valid = 1'b0;
            end
            tick();
            chk($sformatf("t6_f%0d_ready", f), bus.frame_ready, 1);
        end
        tick();
        chk("t6_no_extra_accept", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
